// File: rtl/exe_stage.sv
// exe_stage: execute stage of the five-stage in-order MIPS pipeline.
// Evaluates ALU ops, issues data-SRAM requests, owns HI/LO.
// Define EXE_DIV_EN to build the 32-cycle restoring divider for DIV/DIVU;
// without it div/divu pass through in one cycle and leave HI/LO untouched.
module exe_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         ms_allowin,
    output logic         es_allowin,
    input  logic         ds_to_es_valid,
    input  logic [151:0] ds_to_es_bus,
    output logic         es_to_ms_valid,
    output logic [71:0]  es_to_ms_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_wen,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic [31:0]  es_to_ds_result,
    output logic [4:0]   ES_dest,
    output logic         ES_load
);
    localparam int DS_TO_ES_BUS_WD = 152;

    logic                       es_valid;
    logic                       es_ready_go;
    logic [DS_TO_ES_BUS_WD-1:0] bus_r;

    logic        op_div, op_divu, op_mfhi, op_mflo;
    logic [11:0] alu_op;
    logic        mem_we, res_from_mem, gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_src1, alu_src2, rt_value, pc;
    logic [31:0] alu_result, es_result;
    logic [31:0] hi, lo;

    assign {op_div, op_divu, op_mfhi, op_mflo} = bus_r[151:148];
    assign alu_op       = bus_r[147:136];
    assign mem_we       = bus_r[135];
    assign res_from_mem = bus_r[134];
    assign gr_we        = bus_r[133];
    assign dest         = bus_r[132:128];
    assign alu_src1     = bus_r[127:96];
    assign alu_src2     = bus_r[95:64];
    assign rt_value     = bus_r[63:32];
    assign pc           = bus_r[31:0];

    // Pipeline register between decode and execute
    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid <= 1'b0;
            bus_r    <= '0;
        end else if (es_allowin) begin
            es_valid <= ds_to_es_valid;
            if (ds_to_es_valid)
                bus_r <= ds_to_es_bus;
        end
    end

    // One-hot ALU: add sub slt sltu and nor or xor sll srl sra lui
    always_comb begin
        alu_result = '0;
        if (alu_op[0])  alu_result = alu_result | (alu_src1 + alu_src2);
        if (alu_op[1])  alu_result = alu_result | (alu_src1 - alu_src2);
        if (alu_op[2])  alu_result = alu_result | {31'd0, $signed(alu_src1) < $signed(alu_src2)};
        if (alu_op[3])  alu_result = alu_result | {31'd0, alu_src1 < alu_src2};
        if (alu_op[4])  alu_result = alu_result | (alu_src1 & alu_src2);
        if (alu_op[5])  alu_result = alu_result | ~(alu_src1 | alu_src2);
        if (alu_op[6])  alu_result = alu_result | (alu_src1 | alu_src2);
        if (alu_op[7])  alu_result = alu_result | (alu_src1 ^ alu_src2);
        if (alu_op[8])  alu_result = alu_result | (alu_src2 << alu_src1[4:0]);
        if (alu_op[9])  alu_result = alu_result | (alu_src2 >> alu_src1[4:0]);
        if (alu_op[10]) alu_result = alu_result | 32'($signed(alu_src2) >>> alu_src1[4:0]);
        if (alu_op[11]) alu_result = alu_result | {alu_src2[15:0], 16'd0};
    end

    assign es_result = op_mfhi ? hi : op_mflo ? lo : alu_result;

`ifdef EXE_DIV_EN
    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

    div_state_t  div_state;
    logic [4:0]  count;
    logic [31:0] quo, rem, divisor;
    logic        q_neg, r_neg, by_zero;
    logic [32:0] rem_sh, diff;
    logic [31:0] quo_next, rem_next;
    logic        is_signed_op;
    logic [31:0] abs_src1, abs_src2;

    assign is_signed_op = op_div;
    assign abs_src1     = (is_signed_op && alu_src1[31]) ? -alu_src1 : alu_src1;
    assign abs_src2     = (is_signed_op && alu_src2[31]) ? -alu_src2 : alu_src2;
    assign es_ready_go  = !((op_div || op_divu) && div_state != DIV_DONE);

    // One restoring shift-subtract step; remainder always fits in 32 bits
    always_comb begin
        rem_sh = {rem, quo[31]};
        diff   = rem_sh - {1'b0, divisor};
        if (!diff[32]) begin
            rem_next = diff[31:0];
            quo_next = {quo[30:0], 1'b1};
        end else begin
            rem_next = rem_sh[31:0];
            quo_next = {quo[30:0], 1'b0};
        end
    end

    // Divider FSM; HI/LO are written once on the BUSY->DONE transition
    always_ff @(posedge clk) begin
        if (reset) begin
            div_state <= DIV_IDLE;
            count     <= '0;
            quo       <= '0;
            rem       <= '0;
            divisor   <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            by_zero   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            unique case (div_state)
                DIV_IDLE: begin
                    if (es_valid && (op_div || op_divu)) begin
                        div_state <= DIV_BUSY;
                        count     <= '0;
                        quo       <= abs_src1;
                        rem       <= '0;
                        divisor   <= abs_src2;
                        q_neg     <= is_signed_op && (alu_src1[31] ^ alu_src2[31]);
                        r_neg     <= is_signed_op && alu_src1[31];
                        by_zero   <= (alu_src2 == 32'd0);
                    end
                end
                DIV_BUSY: begin
                    quo   <= quo_next;
                    rem   <= rem_next;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        div_state <= DIV_DONE;
                        lo <= by_zero ? 32'hFFFF_FFFF : (q_neg ? -quo_next : quo_next);
                        hi <= r_neg ? -rem_next : rem_next;
                    end
                end
                DIV_DONE: begin
                    if (es_ready_go && ms_allowin)
                        div_state <= DIV_IDLE;
                end
                default: div_state <= DIV_IDLE;
            endcase
        end
    end
`else
    logic unused_div;
    assign unused_div  = op_div ^ op_divu;
    assign es_ready_go = 1'b1;

    // HI/LO exist for mfhi/mflo but nothing writes them in this build
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end
    end
`endif

    assign es_allowin      = !es_valid || (es_ready_go && ms_allowin);
    assign es_to_ms_valid  = es_valid && es_ready_go;
    assign es_to_ms_bus    = {mem_we, res_from_mem, gr_we, dest, es_result, pc};

    assign data_sram_en    = es_valid && es_ready_go && ms_allowin && (mem_we || res_from_mem);
    assign data_sram_wen   = {4{data_sram_en && mem_we}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = rt_value;

    assign es_to_ds_result = es_result;
    assign ES_dest         = (es_valid && gr_we) ? dest : 5'd0;
    assign ES_load         = es_valid && res_from_mem;

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the five-stage in-order MIPS pipeline, between the decode stage and `mem_stage`. It evaluates ALU operations and issues data-SRAM requests for loads and stores. It owns the HI/LO registers and an iterative 32-cycle radix-2 divider for DIV/DIVU, stalling the pipeline while a divide runs. It forwards its result and destination to decode for bypassing and load-use detection.

## Interface
Parameters: none. Bus widths come from `mycpu.h`: `DS_TO_ES_BUS_WD` = 152 and `ES_TO_MS_BUS_WD` = 72.

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- ms_allowin  in  1  `mem_stage` can accept
- es_allowin  out  1  this stage can accept
- ds_to_es_valid  in  1  decode offers an instruction
- ds_to_es_bus  in  152  fields, MSB first:
  - hilo_op[3:0] at [151:148], bits {div, divu, mfhi, mflo}
  - alu_op[11:0] at [147:136], passed to the existing `alu`
  - mem_we [135], res_from_mem [134], gr_we [133], dest[4:0] [132:128]
  - alu_src1 [127:96], alu_src2 [95:64], rt_value [63:32], pc [31:0]
- es_to_ms_valid  out  1  instruction ready for `mem_stage`
- es_to_ms_bus  out  72  {mem_we[71], res_from_mem[70], gr_we[69], dest[68:64], es_result[63:32], pc[31:0]}
- data_sram_en  out  1  data SRAM request
- data_sram_wen  out  4  byte write enables
- data_sram_addr  out  32  address = ALU result
- data_sram_wdata  out  32  rt_value
- es_to_ds_result  out  32  bypass value (es_result)
- ES_dest  out  5  dest gated: 0 unless es_valid && gr_we
- ES_load  out  1  es_valid && res_from_mem (load-use stall)

## Operation
- Bus register latches ds_to_es_bus when `ds_to_es_valid && es_allowin`. es_valid <= ds_to_es_valid when es_allowin.
- es_allowin = !es_valid || (es_ready_go && ms_allowin). es_to_ms_valid = es_valid && es_ready_go.
- es_ready_go = 1 unless the op is a div/divu and div_state != DONE.
- es_result:
  - mfhi selects HI; mflo selects LO.
  - Otherwise `alu` output on alu_src1/alu_src2.
  - div/divu results pass the ALU output but must not be consumed; decode sets gr_we=0 for them.
- SRAM request: data_sram_en = es_valid && es_ready_go && ms_allowin && (mem_we || res_from_mem). data_sram_wen = {4{data_sram_en && mem_we}}. Word accesses only.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE→BUSY when es_valid && (div || divu). Latch |src1|, |src2| (unsigned for divu), result signs, and count=0.
  - BUSY runs one restoring shift-subtract step per cycle. count 0..31; →DONE when count==31.
  - On entering DONE, write LO=quotient and HI=remainder exactly once. Sign fixes: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - DONE→IDLE when es_ready_go && ms_allowin.
- Divide by zero: LO=0xFFFFFFFF, HI=dividend (src1), still 32 cycles.
- 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
- Reset at any point: es_valid=0, div_state=IDLE, count=0, HI=LO=0. Any in-flight divide is discarded.

## Timing
- Reset values: es_allowin=1, es_to_ms_valid=0, data_sram_en=0, data_sram_wen=0, ES_dest=0, ES_load=0. Bus-derived outputs are don't-care while es_valid=0.
- Non-divide op: 1 cycle in the stage, zero extra latency. The SRAM request is issued in the same cycle the instruction moves to `mem_stage`.
- Divide sequence, with the div entering ES in cycle T:
  - T: IDLE, start the divide.
  - T+1..T+32: BUSY.
  - Edge ending T+32: enter DONE and write HI/LO.
  - T+33: es_ready_go=1; the div leaves if ms_allowin.
- An mfhi/mflo following a div reads the updated HI/LO, because HI/LO are written before the div leaves.
- ms_allowin=0 holds the stage. No SRAM request is issued and the bus is stable. The divider stays in DONE.

## Configuration
- `EXE_DIV_EN` defined: divider FSM and HI/LO writes by div/divu are built as above.
- `EXE_DIV_EN` undefined: no divider logic. div/divu complete in 1 cycle and leave HI/LO unchanged. es_ready_go is constant 1. mfhi/mflo still read HI/LO (0 after reset).

## Test plan
- ADDU src1=5, src2=7 with ms_allowin=1: es_to_ms_valid one cycle after entry, bus[63:32]=12, ES_dest=dest.
- SW addr 0x100, rt_value=0xDEADBEEF: data_sram_en=1, wen=0xF, addr=0x100, wdata=0xDEADBEEF. Repeat with ms_allowin=0: en=0 until it is released.
- DIV −7/2, then MFLO and MFHI: es_allowin=0 for 33 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF, mflo result 0xFFFFFFFD.
- DIVU 0x80000000/0 → LO=0xFFFFFFFF, HI=0x80000000. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Assert reset at BUSY count=10: next cycle es_valid=0, state IDLE, HI=LO=0. A following DIVU 9/3 gives LO=3, HI=0.
- LW in ES: ES_load=1 and ES_dest=dest. An instruction with gr_we=0 gives ES_dest=0.
